hbuf_pg_reader: RTL and testbench

Hit buffer page reader: the read-side counterpart of the mDOM hit buffer controller. It issues DDR3 page read requests for the oldest used hit-buffer page and checks the returned 2048×16-bit page (header, sync words, word count, CRC16) from a 64-bit page DPRAM read port. It streams the valid waveform words of good pages to a 64-bit downstream consumer, then frees the page through the controller's `pg_clr` handshake.

---
 rtl/hbuf_pg_reader_pkg.sv | 37 +++
 rtl/crc16_64b_parallel.sv | 35 +++
 rtl/hbuf_rd_skid.sv | 65 ++++++
 rtl/hbuf_pg_reader.sv | 216 +++++++++++++++++++++
 tb/tb_hbuf_pg_reader.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hbuf_pg_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hbuf_pg_reader_pkg
// Purpose  : Shared constants, state encodings and stream word type for the
//            hit buffer page reader.
// Revision : 1.0 - initial release
// ============================================================================
package hbuf_pg_reader_pkg;

    localparam logic [63:0] c_pg_header   = {16'h5555, 16'hAAAA, 16'h5555, 16'hA000};
    localparam logic [31:0] c_footer_sync = {16'h5555, 16'hAAAA};

    localparam int LAST_PG_DPRAM_ADDR  = 511;
    localparam int PG_DPRAM_RD_LATENCY = 2;
    localparam int SKID_DEPTH          = 4;

    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_REQ          = 3'd1;
    localparam logic [2:0] S_ACK_LOW_WAIT = 3'd2;
    localparam logic [2:0] S_VERIFY       = 3'd3;
    localparam logic [2:0] S_CHECK        = 3'd4;
    localparam logic [2:0] S_STREAM       = 3'd5;
    localparam logic [2:0] S_CLR          = 3'd6;
    localparam logic [2:0] S_CLR_ACK_WAIT = 3'd7;

    typedef struct packed {
        logic        last;
        logic [63:0] data;
    } stream_word_t;

    // The CRC consumes the first-stored 16-bit lane first.
    function automatic logic [63:0] lane_reverse(input logic [63:0] d);
        return {d[15:0], d[31:16], d[47:32], d[63:48]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc16_64b_parallel.sv
`default_nettype none
// ============================================================================
// Module   : crc16_64b_parallel
// Purpose  : CRC16 (poly 0x8005, init 0xFFFF) over 64 bits per cycle, MSB first.
// Revision : 1.0 - initial release
// ============================================================================
module crc16_64b_parallel (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_init,
    input  logic        i_en,
    input  logic [63:0] i_data,
    output logic [15:0] o_crc
);
    logic [15:0] r_crc_q;
    logic [15:0] w_crc_d;

    always_comb begin
        logic [15:0] v;
        v = i_init ? 16'hFFFF : r_crc_q;
        for (int i = 63; i >= 0; i--) begin
            v = {v[14:0], 1'b0} ^ ((v[15] ^ i_data[i]) ? 16'h8005 : 16'h0000);
        end
        w_crc_d = i_en ? v : r_crc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) r_crc_q <= 16'hFFFF;
        else     r_crc_q <= w_crc_d;
    end

    assign o_crc = r_crc_q;

endmodule
`default_nettype wire

// File: rtl/hbuf_rd_skid.sv
`default_nettype none
// ============================================================================
// Module   : hbuf_rd_skid
// Purpose  : Shift-register output skid buffer; head entry drives the stream.
// Revision : 1.0 - initial release
// ============================================================================
module hbuf_rd_skid
    import hbuf_pg_reader_pkg::*;
#(
    parameter int DEPTH = SKID_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  stream_word_t                 i_word,
    input  logic                         i_ready,
    output logic                         o_valid,
    output stream_word_t                 o_word,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int CW = $clog2(DEPTH + 1);

    stream_word_t  r_mem_q [DEPTH];
    stream_word_t  w_mem_d [DEPTH];
    logic [CW-1:0] r_cnt_q, w_cnt_d, w_wr_idx;
    logic          r_valid_q, w_valid_d, w_pop;

    // The writer guarantees room, so a push never lands on a full buffer.
    always_comb begin
        w_pop    = r_valid_q && i_ready;
        w_wr_idx = w_pop ? r_cnt_q - CW'(1) : r_cnt_q;
        for (int i = 0; i < DEPTH; i++) begin
            w_mem_d[i] = r_mem_q[i];
        end
        if (w_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                w_mem_d[i] = r_mem_q[i+1];
            end
            w_mem_d[DEPTH-1] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (i_push && (w_wr_idx == CW'(i))) w_mem_d[i] = i_word;
        end
        w_cnt_d   = i_push ? w_wr_idx + CW'(1) : w_wr_idx;
        w_valid_d = (w_cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q   <= '0;
            r_valid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem_q[i] <= '0;
        end else begin
            r_cnt_q   <= w_cnt_d;
            r_valid_q <= w_valid_d;
            for (int i = 0; i < DEPTH; i++) r_mem_q[i] <= w_mem_d[i];
        end
    end

    assign o_valid = r_valid_q;
    assign o_word  = r_mem_q[0];
    assign o_count = r_cnt_q;

endmodule
`default_nettype wire

// File: rtl/hbuf_pg_reader.sv
`default_nettype none
// ============================================================================
// Module   : hbuf_pg_reader
// Purpose  : Reads the oldest hit-buffer page, verifies header/footer/CRC,
//            streams the data words of good pages and frees the page.
// Revision : 1.0 - initial release
// ============================================================================
module hbuf_pg_reader
    import hbuf_pg_reader_pkg::*;
#(
    parameter int P_ERR_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       empty,
    input  logic [15:0]                rd_pg_num,
    output logic                       pg_req,
    output logic                       pg_optype,
    output logic [27:0]                pg_addr,
    input  logic                       pg_ack,
    output logic [8:0]                 pg_rd_addr,
    input  logic [63:0]                pg_rd_dout,
    output logic [15:0]                pg_clr_cnt,
    output logic                       pg_clr_req,
    input  logic                       pg_clr_ack,
    output logic [63:0]                out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic [P_ERR_CNT_WIDTH-1:0] hdr_err_cnt,
    output logic [P_ERR_CNT_WIDTH-1:0] crc_err_cnt,
    output logic                       busy
);
    localparam int LAT = PG_DPRAM_RD_LATENCY;

    logic                       w_rst;
    logic [2:0]                 r_state_q, w_state_d;
    logic [27:0]                r_pg_addr_q, w_pg_addr_d;
    logic [8:0]                 r_rd_addr_q, w_rd_addr_d;
    logic                       r_rd_v_q, w_rd_v_d;
    logic [LAT-1:0]             r_vld_pipe_q, w_vld_pipe_d;
    logic [8:0]                 r_idx_pipe_q [LAT];
    logic [8:0]                 w_idx_pipe_d [LAT];
    logic                       r_hdr_ok_q, w_hdr_ok_d;
    logic [63:0]                r_footer_q, w_footer_d;
    logic [8:0]                 r_d_cnt_q, w_d_cnt_d;
    logic [P_ERR_CNT_WIDTH-1:0] r_hdr_err_q, w_hdr_err_d, r_crc_err_q, w_crc_err_d;
    logic                       r_pg_req_q, r_clr_req_q, r_busy_q;

    logic                       w_arr_v, w_crc_init, w_crc_en, w_hdr_bad, w_crc_bad;
    logic [8:0]                 w_arr_idx, w_d_words;
    logic [15:0]                w_crc, w_nwords;
    logic [3:0]                 w_pipe_cnt, w_outstanding;
    logic                       w_push, w_pop, w_skid_valid;
    stream_word_t               w_push_word, w_head;
    logic [$clog2(SKID_DEPTH+1)-1:0] w_skid_cnt;

    assign w_rst     = rst || !en;
    assign w_arr_v   = r_vld_pipe_q[LAT-1];
    assign w_arr_idx = r_idx_pipe_q[LAT-1];
    assign w_pop     = w_skid_valid && out_ready;

    assign w_crc_init = (r_state_q == S_VERIFY) && w_arr_v && (w_arr_idx == 9'd1);
    assign w_crc_en   = (r_state_q == S_VERIFY) && w_arr_v && (w_arr_idx != 9'd0)
                        && (w_arr_idx != 9'(LAST_PG_DPRAM_ADDR));

    crc16_64b_parallel u_crc (
        .clk    (clk),
        .rst    (w_rst),
        .i_init (w_crc_init),
        .i_en   (w_crc_en),
        .i_data (lane_reverse(pg_rd_dout)),
        .o_crc  (w_crc)
    );

    assign w_nwords  = r_footer_q[47:32];
    assign w_hdr_bad = !r_hdr_ok_q || (r_footer_q[31:0] != c_footer_sync) ||
                       (w_nwords[1:0] != 2'b00) || (w_nwords < 16'd4) || (w_nwords > 16'd2044);
    assign w_crc_bad = !w_hdr_bad && (w_crc != r_footer_q[63:48]);
    assign w_d_words = 9'(w_nwords[15:2] - 14'd1);

    // Read credit: words in the skid, in the DPRAM pipe and being issued now.
    always_comb begin
        w_pipe_cnt = '0;
        for (int i = 0; i < LAT; i++) w_pipe_cnt = w_pipe_cnt + 4'(r_vld_pipe_q[i]);
        w_outstanding = 4'(w_skid_cnt) + w_pipe_cnt + 4'(r_rd_v_q) - 4'(w_pop);
        w_vld_pipe_d    = {r_vld_pipe_q[LAT-2:0], r_rd_v_q};
        w_idx_pipe_d[0] = r_rd_addr_q;
        for (int i = 1; i < LAT; i++) w_idx_pipe_d[i] = r_idx_pipe_q[i-1];
        w_push           = (r_state_q == S_STREAM) && w_arr_v;
        w_push_word.last = (w_arr_idx == r_d_cnt_q);
        w_push_word.data = pg_rd_dout;
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_pg_addr_d = r_pg_addr_q;
        w_rd_addr_d = r_rd_addr_q;
        w_rd_v_d    = 1'b0;
        w_hdr_ok_d  = r_hdr_ok_q;
        w_footer_d  = r_footer_q;
        w_d_cnt_d   = r_d_cnt_q;
        w_hdr_err_d = r_hdr_err_q;
        w_crc_err_d = r_crc_err_q;
        case (r_state_q)
            S_IDLE: if (!empty) begin
                w_state_d   = S_REQ;
                w_pg_addr_d = {1'b0, rd_pg_num, 11'b0};
            end
            S_REQ: if (pg_ack) w_state_d = S_ACK_LOW_WAIT;
            S_ACK_LOW_WAIT: if (!pg_ack) begin
                w_state_d   = S_VERIFY;
                w_rd_addr_d = '0;
                w_rd_v_d    = 1'b1;
            end
            S_VERIFY: begin
                if (r_rd_v_q && (r_rd_addr_q != 9'(LAST_PG_DPRAM_ADDR))) begin
                    w_rd_addr_d = r_rd_addr_q + 9'd1;
                    w_rd_v_d    = 1'b1;
                end
                if (w_arr_v && (w_arr_idx == 9'd0)) w_hdr_ok_d = (pg_rd_dout == c_pg_header);
                if (w_arr_v && (w_arr_idx == 9'(LAST_PG_DPRAM_ADDR))) begin
                    w_footer_d = pg_rd_dout;
                    w_state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                w_d_cnt_d = w_d_words;
                if (w_hdr_bad) begin
                    if (!(&r_hdr_err_q)) w_hdr_err_d = r_hdr_err_q + P_ERR_CNT_WIDTH'(1);
                    w_state_d = S_CLR;
                end else if (w_crc_bad) begin
                    if (!(&r_crc_err_q)) w_crc_err_d = r_crc_err_q + P_ERR_CNT_WIDTH'(1);
                    w_state_d = S_CLR;
                end else if (w_d_words == 9'd0) begin
                    w_state_d = S_CLR;
                end else begin
                    w_state_d   = S_STREAM;
                    w_rd_addr_d = 9'd1;
                    w_rd_v_d    = 1'b1;
                end
            end
            S_STREAM: begin
                if ((r_rd_addr_q < r_d_cnt_q) && (w_outstanding < 4'(SKID_DEPTH))) begin
                    w_rd_addr_d = r_rd_addr_q + 9'd1;
                    w_rd_v_d    = 1'b1;
                end
                if (w_pop && w_head.last) w_state_d = S_CLR;
            end
            S_CLR:          if (pg_clr_ack)  w_state_d = S_CLR_ACK_WAIT;
            S_CLR_ACK_WAIT: if (!pg_clr_ack) w_state_d = S_IDLE;
            default:        w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_state_q    <= S_IDLE;
            r_pg_addr_q  <= '0;
            r_rd_addr_q  <= '0;
            r_rd_v_q     <= 1'b0;
            r_vld_pipe_q <= '0;
            for (int i = 0; i < LAT; i++) r_idx_pipe_q[i] <= '0;
            r_hdr_ok_q   <= 1'b0;
            r_footer_q   <= '0;
            r_d_cnt_q    <= '0;
            r_hdr_err_q  <= '0;
            r_crc_err_q  <= '0;
            r_pg_req_q   <= 1'b0;
            r_clr_req_q  <= 1'b0;
            r_busy_q     <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_pg_addr_q  <= w_pg_addr_d;
            r_rd_addr_q  <= w_rd_addr_d;
            r_rd_v_q     <= w_rd_v_d;
            r_vld_pipe_q <= w_vld_pipe_d;
            for (int i = 0; i < LAT; i++) r_idx_pipe_q[i] <= w_idx_pipe_d[i];
            r_hdr_ok_q   <= w_hdr_ok_d;
            r_footer_q   <= w_footer_d;
            r_d_cnt_q    <= w_d_cnt_d;
            r_hdr_err_q  <= w_hdr_err_d;
            r_crc_err_q  <= w_crc_err_d;
            r_pg_req_q   <= (w_state_d == S_REQ);
            r_clr_req_q  <= (w_state_d == S_CLR);
            r_busy_q     <= (w_state_d != S_IDLE);
        end
    end

    hbuf_rd_skid #(.DEPTH(SKID_DEPTH)) u_skid (
        .clk     (clk),
        .rst     (w_rst),
        .i_push  (w_push),
        .i_word  (w_push_word),
        .i_ready (out_ready),
        .o_valid (w_skid_valid),
        .o_word  (w_head),
        .o_count (w_skid_cnt)
    );

    assign pg_req      = r_pg_req_q;
    assign pg_optype   = 1'b0;
    assign pg_addr     = r_pg_addr_q;
    assign pg_rd_addr  = r_rd_addr_q;
    assign pg_clr_cnt  = 16'd1;
    assign pg_clr_req  = r_clr_req_q;
    assign out_data    = w_head.data;
    assign out_last    = w_head.last;
    assign out_valid   = w_skid_valid;
    assign hdr_err_cnt = r_hdr_err_q;
    assign crc_err_cnt = r_crc_err_q;
    assign busy        = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_hbuf_pg_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_hbuf_pg_reader
// Purpose  : Randomized page-level bench with a behavioural page/stream model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hbuf_pg_reader;

    logic        clk = 1'b0;
    logic        rst, en, empty, pg_ack, pg_clr_ack, out_ready;
    logic [15:0] rd_pg_num;
    logic        pg_req, pg_optype, pg_clr_req, out_valid, out_last, busy;
    logic [27:0] pg_addr;
    logic [8:0]  pg_rd_addr;
    logic [63:0] pg_rd_dout, out_data;
    logic [15:0] pg_clr_cnt, hdr_err_cnt, crc_err_cnt;

    always #5 clk = ~clk;

    hbuf_pg_reader #(.P_ERR_CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .en(en), .empty(empty), .rd_pg_num(rd_pg_num),
        .pg_req(pg_req), .pg_optype(pg_optype), .pg_addr(pg_addr), .pg_ack(pg_ack),
        .pg_rd_addr(pg_rd_addr), .pg_rd_dout(pg_rd_dout), .pg_clr_cnt(pg_clr_cnt),
        .pg_clr_req(pg_clr_req), .pg_clr_ack(pg_clr_ack), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .hdr_err_cnt(hdr_err_cnt), .crc_err_cnt(crc_err_cnt), .busy(busy)
    );

    // Page DPRAM with two register stages of read latency.
    logic [63:0] mem [512];
    logic [63:0] rd_p1, rd_p2;
    always @(posedge clk) begin
        rd_p1 <= mem[pg_rd_addr];
        rd_p2 <= rd_p1;
    end
    assign pg_rd_dout = rd_p2;

    int          n_cmp = 0, n_fail = 0;
    logic [63:0] exp_q [$];
    int          rx_words, clr_count, ack_dly, clr_dly;
    int          exp_hdr, exp_crc;
    bit          ready_rand;
    logic [27:0] exp_addr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] model_crc();
        logic [15:0] c = 16'hFFFF;
        for (int w = 1; w <= 510; w++)
            for (int l = 0; l < 4; l++) begin
                logic [15:0] v = mem[w][16*l +: 16];
                for (int b = 15; b >= 0; b--) begin
                    bit fb = c[15] ^ v[b];
                    c = {c[14:0], 1'b0};
                    if (fb) c = c ^ 16'h8005;
                end
            end
        return c;
    endfunction

    function automatic bit model_hdr_bad(input logic [63:0] w0, input logic [63:0] w511);
        int n = int'(w511[47:32]);
        return (w0 != 64'h5555AAAA5555A000) || (w511[31:0] != 32'h5555AAAA) ||
               (n % 4 != 0) || (n < 4) || (n > 2044);
    endfunction

    // Stream checker and out_ready driver.
    initial begin
        logic [63:0] prev_data;
        logic        prev_last;
        bit          stall_prev = 0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                out_ready  = 1'b0;
                stall_prev = 0;
                continue;
            end
            if (stall_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
                chk("hold_last", out_last, prev_last);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_word: got %h expected no word", out_data);
                end else begin
                    chk("out_data", out_data, exp_q[0]);
                    chk("out_last", out_last, exp_q.size() == 1);
                end
            end
            out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                rx_words++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    // Controller / DDR3 handshake responder.
    initial begin
        int  req_wait = 0, clr_wait = 0;
        bit  req_on = 0, clr_on = 0;
        pg_ack = 1'b0; pg_clr_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pg_ack = 1'b0; pg_clr_ack = 1'b0;
                req_wait = 0; clr_wait = 0; req_on = 0; clr_on = 0;
                continue;
            end
            if (pg_req) begin
                req_on = 1;
                chk("pg_addr", pg_addr, exp_addr);
                chk("pg_optype", pg_optype, 0);
                if (!pg_ack) begin
                    if (req_wait >= ack_dly) pg_ack = 1'b1;
                    else req_wait++;
                end
            end else begin
                if (req_on && !pg_ack) begin
                    n_cmp++; n_fail++;
                    $display("FAIL pg_req_early_drop: got 0 expected 1");
                end
                req_on = 0; req_wait = 0; pg_ack = 1'b0;
            end
            if (pg_clr_req) begin
                clr_on = 1;
                chk("pg_clr_cnt", pg_clr_cnt, 16'd1);
                if (!pg_clr_ack) begin
                    if (clr_wait >= clr_dly) begin
                        pg_clr_ack = 1'b1;
                        clr_count++;
                        empty = 1'b1;
                    end else clr_wait++;
                end
            end else begin
                if (clr_on && !pg_clr_ack) begin
                    n_cmp++; n_fail++;
                    $display("FAIL pg_clr_req_early_drop: got 0 expected 1");
                end
                clr_on = 0; clr_wait = 0; pg_clr_ack = 1'b0;
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pg_req"}, pg_req, 0);
        chk({tag, "_pg_optype"}, pg_optype, 0);
        chk({tag, "_pg_addr"}, pg_addr, 0);
        chk({tag, "_pg_rd_addr"}, pg_rd_addr, 0);
        chk({tag, "_pg_clr_cnt"}, pg_clr_cnt, 1);
        chk({tag, "_pg_clr_req"}, pg_clr_req, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_hdr_err_cnt"}, hdr_err_cnt, 0);
        chk({tag, "_crc_err_cnt"}, crc_err_cnt, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Fill the page, compute what must come out, and release the page.
    task automatic load_page(input int nw, input bit bad_hdr, input bit bad_crc, input logic [15:0] pg);
        logic [15:0] crc;
        int          d;
        bit          hbad, cbad;
        mem[0] = bad_hdr ? 64'h5555AAAA5555A001 : 64'h5555AAAA5555A000;
        for (int w = 1; w <= 510; w++) mem[w] = {$urandom, $urandom};
        crc = model_crc();
        mem[511] = {bad_crc ? crc ^ 16'h0400 : crc, 16'(nw), 16'h5555, 16'hAAAA};
        hbad = model_hdr_bad(mem[0], mem[511]);
        cbad = !hbad && (model_crc() != mem[511][63:48]);
        d    = nw / 4 - 1;
        exp_q.delete();
        if (!hbad && !cbad)
            for (int w = 1; w <= d; w++) exp_q.push_back(mem[w]);
        if (hbad) exp_hdr++;
        if (cbad) exp_crc++;
        rx_words  = 0;
        exp_addr  = {1'b0, pg, 11'b0};
        rd_pg_num = pg;
        empty     = 1'b0;
    endtask

    task automatic finish_page(input string tag, input int exp_words, input int clr0);
        int cyc = 0;
        while (!(clr_count != clr0 && !busy) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 20000) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: got busy=%0d clr=%0d expected page freed", tag, busy, clr_count - clr0);
        end
        chk({tag, "_words"}, rx_words, exp_words);
        chk({tag, "_left"}, exp_q.size(), 0);
        chk({tag, "_clr_pulses"}, clr_count - clr0, 1);
        chk({tag, "_hdr_err"}, hdr_err_cnt, exp_hdr);
        chk({tag, "_crc_err"}, crc_err_cnt, exp_crc);
    endtask

    task automatic run_page(input string tag, input int nw, input bit bad_hdr, input bit bad_crc,
                            input logic [15:0] pg);
        int c0 = clr_count;
        load_page(nw, bad_hdr, bad_crc, pg);
        finish_page(tag, exp_q.size(), c0);
    endtask

    initial begin
        int cyc, c0, nsz;
        rst = 1'b1; en = 1'b1; empty = 1'b1; rd_pg_num = 16'h0;
        ready_rand = 0; ack_dly = 2; clr_dly = 2;
        clr_count = 0; exp_hdr = 0; exp_crc = 0; rx_words = 0; exp_addr = '0;
        for (int i = 0; i < 512; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_page("good16", 16, 0, 0, 16'h0007);
        chk("good16_d_literal", rx_words, 3);

        ready_rand = 1;
        run_page("full", 2044, 0, 0, 16'h0100);
        chk("full_d_literal", rx_words, 510);

        run_page("flush", 4, 0, 0, 16'h0002);
        run_page("badhdr", 16, 1, 0, 16'h0003);
        chk("badhdr_literal", hdr_err_cnt, 1);
        run_page("badcrc", 40, 0, 1, 16'h0004);
        chk("badcrc_literal", crc_err_cnt, 1);

        ack_dly = 100; clr_dly = 50;
        c0 = clr_count;
        load_page(24, 0, 0, 16'h0123);
        cyc = 0;
        while (!pg_req && cyc < 100) begin @(negedge clk); cyc++; end
        chk("pg_addr_literal", pg_addr, 28'h0091800);
        finish_page("slowack", exp_q.size(), c0);
        ack_dly = 2; clr_dly = 2;

        for (int k = 0; k < 3; k++)
            run_page("rand", 4 * int'($urandom_range(1, 511)), 0, 0, 16'($urandom));

        // Reset in the middle of streaming; the page must be re-read in full.
        c0 = clr_count;
        load_page(244, 0, 0, 16'h0055);
        nsz = exp_q.size();
        cyc = 0;
        while (rx_words < 10 && cyc < 5000) begin @(negedge clk); cyc++; end
        chk("midrst_started", rx_words >= 10, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk); @(negedge clk);
        chk_reset_vals("midrst");
        exp_hdr = 0; exp_crc = 0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        for (int w = 1; w <= nsz; w++) exp_q.push_back(mem[w]);
        rx_words = 0;
        finish_page("midrst", nsz, c0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
